// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the execute-stage FSM encoding.
// The ALU control block imports the same op codes, so each code is defined in one place.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per step.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture a (multiplicand) and b (multiplier), clear acc, arm counter to WIDTH
//   a, b       : operands
//   step       : perform one iteration (ignored once the counter reaches 0)
//   acc        : accumulator value *after* the current step (combinational), so the
//                owner can capture the finished product on the same edge as the last step
//   last       : the current step is the final one (counter == 1)
module mul_shift_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CntW-1:0]    count_q;
    logic [2*WIDTH-1:0] addend;

    // Multiplicand is pre-shifted each step, so the addend is either it or zero.
    assign addend = mplr_q[0] ? mcand_q : '0;
    assign acc    = acc_q + addend;
    assign last   = (count_q == CntW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mplr_q  <= b;
            acc_q   <= '0;
            count_q <= CntInit;
        end else if (step && (count_q != '0)) begin
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            acc_q   <= acc;
            count_q <= count_q - CntW'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with a start/busy/done handshake.
// AND/OR/ADD/SUB complete on the start edge; MULT runs WIDTH iterations in mul_shift_add.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : op request, sampled only in IDLE
//   cont            : 4-bit op code from ALU control
//   a, b            : operands
//   result          : registered result (low word for MULT)
//   product_hi      : high word of the last MULT, held across other ops
//   zero            : registered result == 0
//   busy            : MULT in progress
//   done, illegal   : one-cycle registered pulses on completion / undefined op
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cont,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] product_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   alu_out;

    mul_shift_add #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .a     (a),
        .b     (b),
        .step  (mul_step),
        .acc   (mul_acc),
        .last  (mul_last)
    );

    // Single-cycle datapath; all arithmetic is modulo 2^WIDTH.
    always_comb begin
        alu_out = '0;
        case (cont)
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_ADD: alu_out = a + b;
            ALU_SUB: alu_out = a + ~b + WIDTH'(1);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (cont)
                        ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: begin
                            result_d = alu_out;
                            zero_d   = (alu_out == '0);
                            done_d   = 1'b1;
                        end
                        ALU_MUL: begin
                            mul_load = 1'b1;
                            state_d  = ST_MUL;
                        end
                        default: begin
                            result_d  = '0;
                            zero_d    = 1'b1;
                            done_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                // start is deliberately ignored here; requests are not queued.
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_acc[WIDTH-1:0];
                    hi_d     = mul_acc[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_acc[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign result     = result_q;
    assign product_hi = hi_q;
    assign zero       = zero_q;
    assign busy       = (state_q == ST_MUL);
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule
